pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program counter for the fetch stage. Feeds the instruction address to the BIOS ROM and instruction memory.
//  Consumes ResetPC from the BIOS/memory instruction-select controller. Applies branch/jump redirects, stalls,
//  and halt/resume, and qualifies each fetched word with FetchValid.
// PARAMETERS
//  ADDR_W        10     PC width; instructions are word addressed
//  RESET_VECTOR  0      PC value after Reset or ResetPC
//  MEM_WORDS     1024   highest legal PC + 1 (used only with PC_BOUNDS_CHECK_EN)
// PORTS
//  CLK           in   1       clock, all state updates on posedge
//  Reset         in   1       asynchronous, active-high
//  ResetPC       in   1       synchronous PC restart request from instruction-select controller
//  Stall         in   1       hold PC this cycle (downstream hazard)
//  Halt          in   1       decoded HALT at current PC
//  Resume        in   1       leave HALTED (external input/ack)
//  Jump          in   1       unconditional redirect
//  JumpTarget    in   ADDR_W  jump destination
//  BranchTaken   in   1       resolved taken branch
//  BranchTarget  in   ADDR_W  branch destination
//  PC            out  ADDR_W  current fetch address
//  PCPlus1       out  ADDR_W  PC+1 mod 2^ADDR_W, combinational (link value for JAL)
//  FetchValid    out  1       instruction at PC is valid this cycle
//  Halted        out  1       FSM in HALTED
//  PCFault       out  1       sticky out-of-range fault (0 when feature absent)
// BEHAVIOUR
//  Reset (async): PC=RESET_VECTOR, state=FLUSH, FetchValid=0, Halted=0, PCFault=0.
//  FSM states: RUN, HALTED, FLUSH. Registered outputs: PC, state, PCFault. FetchValid = (state==RUN).
//  Halted = (state==HALTED).
//  Per-edge priority, highest first:
//   1 ResetPC (any state): PC<=RESET_VECTOR, state<=FLUSH, PCFault<=0.
//   2 FLUSH: PC held, state<=RUN. FLUSH is exactly one cycle; it covers the BIOS->memory select switch.
//   3 HALTED: Resume -> PC<=PC+1, state<=RUN; else hold. Jump/Branch/Stall ignored.
//   4 RUN & Stall: hold PC. Halt/Jump/Branch ignored (instruction not committed).
//   5 RUN & Halt: hold PC, state<=HALTED.
//   6 RUN & Jump: PC<=JumpTarget. Jump beats BranchTaken when both asserted.
//   7 RUN & BranchTaken: PC<=BranchTarget.
//   8 RUN otherwise: PC<=PC+1. Wraps 2^ADDR_W-1 -> 0 silently.
//  Latency: redirect inputs sampled at edge N; new PC visible after edge N. No delay slot.
//  Resume asserted while not HALTED: ignored. Halt+Resume same cycle in RUN: enters HALTED.
//  Reset mid-operation: clears all state immediately, regardless of FSM state.
// CONFIGURATION
//  PC_BOUNDS_CHECK_EN defined: in RUN, if the next PC selected by rules 6-8 is >= MEM_WORDS, PC holds,
//   PCFault<=1, state<=HALTED. The check applies to wrap-around too. Resume does not clear PCFault; Resume
//   from a fault-halt re-applies the check. Only Reset or ResetPC clears PCFault.
//  PC_BOUNDS_CHECK_EN undefined: no range check, PCFault tied 0, MEM_WORDS unused.
// TESTING
//  T1 Reset pulse, then 3 idle clocks -> PC 0,0,1,2. FetchValid 0 on the first cycle after reset, then 1.
//  T2 At PC=5, assert Jump=1 (JumpTarget=40) and BranchTaken=1 (BranchTarget=9) together -> PC=40.
//     Next edge -> 41.
//  T3 At PC=7, assert Stall 2 cycles with Halt=1 -> PC stays 7, Halted=0. Release Stall, keep Halt -> Halted=1,
//     PC=7. Resume -> PC=8, FetchValid=1.
//  T4 At PC=12 in RUN and again in HALTED, pulse ResetPC -> PC=0, FetchValid=0 for one cycle, then PC=1.
//  T5 ADDR_W=4, no macro, run from 0 -> PC reaches 15 then wraps to 0. PCFault stays 0.
//  T6 PC_BOUNDS_CHECK_EN, MEM_WORDS=20: BranchTarget=25 at PC=3 -> PC=3, PCFault=1, Halted=1.
//     ResetPC -> PCFault=0, PC=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: redirects, stalls, halt/resume, fetch qualify.
// Optional range check enabled by defining PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
    parameter int                 ADDR_W       = 10,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 MEM_WORDS    = 1024
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ResetPC,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Resume,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus1,
    output logic              FetchValid,
    output logic              Halted,
    output logic              PCFault
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // A memory of zero words can hold no program at all.
    if (MEM_WORDS < 1) begin : g_bad_cfg
        $error("pc_sequencer: MEM_WORDS must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] run_next;
    logic              oob_run;
    logic              oob_inc;

    // Sequential successor and the redirect-selected next PC (Jump beats branch).
    always_comb begin
        pc_inc   = pc_q + ADDR_W'(1);
        run_next = pc_inc;
        if (Jump) begin
            run_next = JumpTarget;
        end else if (BranchTaken) begin
            run_next = BranchTarget;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    // Wrapped values are checked like any other candidate address.
    always_comb begin
        oob_run = 32'(run_next) >= MEM_WORDS;
        oob_inc = 32'(pc_inc) >= MEM_WORDS;
    end
`else
    // No range check: every address is fetchable.
    always_comb begin
        oob_run = 1'b0;
        oob_inc = 1'b0;
    end
`endif

    // Next-state selection, highest-priority condition first.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        fault_d = fault_q;
        if (ResetPC) begin
            pc_d    = RESET_VECTOR;
            state_d = ST_FLUSH;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                ST_HALTED: begin
                    if (Resume) begin
                        if (oob_inc) begin
                            fault_d = 1'b1;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (Stall) begin
                        pc_d = pc_q;
                    end else if (Halt) begin
                        state_d = ST_HALTED;
                    end else if (oob_run) begin
                        fault_d = 1'b1;
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = run_next;
                    end
                end
                default: begin
                    state_d = ST_FLUSH;
                end
            endcase
        end
    end

    // State registers; async reset restarts in FLUSH at the reset vector.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_FLUSH;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign PC         = pc_q;
    assign PCPlus1    = pc_inc;
    assign FetchValid = (state_q == ST_RUN);
    assign Halted     = (state_q == ST_HALTED);
    assign PCFault    = fault_q;

endmodule
